ysyx_25040111_mem_arbiter: RTL

//  Shares the single memory port between instruction fetch (IFU) and load/store (LSU).

---
 rtl/ysyx_25040111_mem_arbiter_pkg.sv | 17 +
 rtl/ysyx_25040111_mem_arbiter_rr_pick.sv | 28 ++
 rtl/ysyx_25040111_mem_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040111_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM state encoding and owner codes.
package ysyx_25040111_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    // Owner code doubles as the bit index of that requester in the picker's req/gnt vectors.
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/ysyx_25040111_mem_arbiter_rr_pick.sv
// Two-way grant picker: fixed LSU priority or alternate-on-tie, one-hot grant, combinational.
module ysyx_25040111_rr_pick
    import ysyx_25040111_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last,
    input  logic       prio_mode,
    output logic [1:0] gnt
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (prio_mode || last == OWN_IFU) begin
                    gnt = 2'b10;
                end else begin
                    gnt = 2'b01;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_25040111_mem_arbiter.sv
// Shares one valid/ready memory port between IFU and LSU, one transaction at a time,
// with a timeout that answers with an error response when memory never replies.
module ysyx_25040111_mem_arbiter
    import ysyx_25040111_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LSU_PRIO = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                resp_err,

    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rerr,

    output logic                busy,
    output logic                arb_conflict
);

    // Counter can reach TIMEOUT when the handshake lands exactly on the expiry cycle.
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        state;
    owner_e            owner;
    owner_e            last_owner;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        gnt;
    logic              expired;
    logic              finish;
    logic [DATA_W-1:0] fin_data;
    logic              fin_err;

    ysyx_25040111_rr_pick u_pick (
        .req       ({lsu_req, ifu_req}),
        .last      (last_owner),
        .prio_mode (LSU_PRIO != 0),
        .gnt       (gnt)
    );

    assign expired = (cnt >= CNT_LAST);

    // A response in WAIT beats expiry; an accept in ISSUE beats expiry too.
    always_comb begin
        finish   = 1'b0;
        fin_data = '0;
        fin_err  = 1'b0;
        if (state == ST_WAIT && mem_rvalid) begin
            finish   = 1'b1;
            fin_data = mem_rdata;
            fin_err  = mem_rerr;
        end else if (expired && (state == ST_WAIT || (state == ST_ISSUE && !mem_ready))) begin
            finish  = 1'b1;
            fin_err = 1'b1;
        end
    end

    // NOTE: all state here is registered with non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            owner          <= OWN_IFU;
            last_owner     <= OWN_LSU;
            cnt            <= '0;
            mem_valid      <= 1'b0;
            mem_addr       <= '0;
            mem_wen        <= 1'b0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            lsu_rdata      <= '0;
            resp_err       <= 1'b0;
            busy           <= 1'b0;
            arb_conflict   <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            arb_conflict   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        state        <= ST_ISSUE;
                        busy         <= 1'b1;
                        cnt          <= '0;
                        mem_valid    <= 1'b1;
                        arb_conflict <= ifu_req & lsu_req;
                        if (gnt[OWN_LSU]) begin
                            owner      <= OWN_LSU;
                            last_owner <= OWN_LSU;
                            mem_addr   <= lsu_addr;
                            mem_wen    <= lsu_wen;
                            mem_wdata  <= lsu_wdata;
                            mem_wmask  <= lsu_wmask;
                        end else begin
                            owner      <= OWN_IFU;
                            last_owner <= OWN_IFU;
                            mem_addr   <= ifu_addr;
                            mem_wen    <= 1'b0;
                            mem_wdata  <= '0;
                            mem_wmask  <= '0;
                        end
                    end
                end

                ST_ISSUE, ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (finish) begin
                        state     <= ST_DONE;
                        mem_valid <= 1'b0;
                        resp_err  <= fin_err;
                        if (owner == OWN_LSU) begin
                            lsu_rdata      <= fin_data;
                            lsu_resp_valid <= 1'b1;
                        end else begin
                            ifu_rdata      <= fin_data;
                            ifu_resp_valid <= 1'b1;
                        end
                    end else if (state == ST_ISSUE && mem_ready) begin
                        state     <= ST_WAIT;
                        mem_valid <= 1'b0;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
